// File: rtl/reg_file.sv
// RISC-V integer register file: 31 storage registers (x0 hardwired to zero),
// two combinational read ports with same-cycle write-back forwarding.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREG = 1 << ADDR_W;

  // x0 has no storage, so the array starts at index 1.
  logic [DATA_W-1:0] regs [1:NREG-1];

  logic wr_valid;
  assign wr_valid = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets decode see the write-back value in the same cycle it is written.
  always_comb begin
    rdata1 = '0;
    if (rst || raddr1 == '0 || !re1) begin
      rdata1 = '0;
    end else if (we && raddr1 == waddr) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst || raddr2 == '0 || !re2) begin
      rdata2 = '0;
    end else if (we && raddr2 == waddr) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic, all compared against an array-based architectural model.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  // Architectural view of x0..x31; x0 entry is never written.
  logic [31:0] model [0:31];

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] expectRead(input logic r, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic re, input logic [4:0] ra);
    if (r) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (!re) return 32'h0;
    if (w && ra == wa) return wd;
    return model[ra];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, checks both ports before the edge, then
  // advances the model across the rising edge.
  task automatic applyStimulus(input string tag, input logic r, input logic w,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic e1, input logic [4:0] a1,
                               input logic e2, input logic [4:0] a2);
    logic [31:0] exp1, exp2;
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
    exp1 = expectRead(r, w, wa, wd, e1, a1);
    exp2 = expectRead(r, w, wa, wd, e2, a2);
    checkOutput({tag, "_p1"}, rdata1, exp1);
    checkOutput({tag, "_p2"}, rdata2, exp2);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    @(negedge clk);

    // Reset held two cycles; outputs must be zero regardless of indices.
    applyStimulus("rst_x0", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    applyStimulus("rst_idx", 1'b1, 1'b1, 5'd4, 32'h1234_0000, 1'b1, 5'd4, 1'b1, 5'd17);
    for (int i = 1; i < 32; i++)
      applyStimulus("post_rst", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i));

    // Basic write then read, and a disabled read.
    applyStimulus("wr_x5", 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus("rd_x5", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    applyStimulus("rd_x5_dis", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b0, 5'd5);

    // x0 protection.
    applyStimulus("wr_x0", 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    applyStimulus("rd_x0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    for (int i = 1; i < 32; i += 2)
      applyStimulus("x0_other", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i + 1));

    // Same-cycle bypass on both ports, then the stored value.
    applyStimulus("byp_x7", 1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 1'b1, 5'd7);
    applyStimulus("st_x7", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);

    // Full sweep and dual read of pairs.
    for (int i = 1; i < 32; i++)
      applyStimulus("sweep_wr", 1'b0, 1'b1, 5'(i), i * 32'h0101_0101, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 1; i < 32; i++)
      applyStimulus("sweep_rd", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i));

    // Bypass on port 1 only, then back-to-back writes to one register.
    applyStimulus("byp_p1", 1'b0, 1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd3, 1'b1, 5'd4);
    applyStimulus("b2b_a", 1'b0, 1'b1, 5'd3, 32'h1111_2222, 1'b1, 5'd3, 1'b1, 5'd3);
    applyStimulus("b2b_b", 1'b0, 1'b1, 5'd3, 32'h3333_4444, 1'b1, 5'd3, 1'b0, 5'd3);
    applyStimulus("b2b_rd", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);

    // Reset colliding with a write: register ends up cleared.
    applyStimulus("coll", 1'b1, 1'b1, 5'd9, 32'hAAAA_5555, 1'b1, 5'd9, 1'b1, 5'd9);
    applyStimulus("coll_rd", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);

    // Random traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 39) == 0),
                    1'($urandom),
                    5'($urandom),
                    $urandom,
                    ($urandom_range(0, 3) != 0),
                    5'($urandom),
                    ($urandom_range(0, 3) != 0),
                    5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
